// File: rtl/tdm_demux_4_if.sv
// Link-side bundle for the 4-slot TDM demux: slot word stream in, frame/status out.
// master drives the word stream; slave is the demux.
interface tdm_demux_4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sof;
    logic [WIDTH-1:0] o0;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic [WIDTH-1:0] o3;
    logic             frame_valid;
    logic             s1;
    logic             s0;
    logic             busy;
    logic             sync_err;

    modport master (
        output din, din_valid, sof,
        input  o0, o1, o2, o3, frame_valid, s1, s0, busy, sync_err
    );

    modport slave (
        input  din, din_valid, sof,
        output o0, o1, o2, o3, frame_valid, s1, s0, busy, sync_err
    );
endinterface

// File: rtl/tdm_demux_4.sv
// Purpose: split a 4-slot TDM word stream into four registered channel outputs.
// Latency: frame published on the edge that accepts the slot-3 word, visible next cycle.
// Backpressure: none; every valid word is consumed, stray words outside a frame are dropped.
module tdm_demux_4 #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    tdm_demux_4_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [WIDTH-1:0] shadow0;
    logic [WIDTH-1:0] shadow1;
    logic [WIDTH-1:0] shadow2;
    logic [WIDTH-1:0] o0_q;
    logic [WIDTH-1:0] o1_q;
    logic [WIDTH-1:0] o2_q;
    logic [WIDTH-1:0] o3_q;
    logic             frame_valid_q;
    logic             sync_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            slot          <= 2'd0;
            shadow0       <= '0;
            shadow1       <= '0;
            shadow2       <= '0;
            o0_q          <= '0;
            o1_q          <= '0;
            o2_q          <= '0;
            o3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.sof) begin
                            shadow0 <= bus.din;
                            slot    <= 2'd1;
                            state   <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.sof) begin
                            // Resync: drop the partial frame, this word restarts at slot 0.
                            sync_err_q <= 1'b1;
                            shadow0    <= bus.din;
                            slot       <= 2'd1;
                        end else begin
                            case (slot)
                                2'd0: begin
                                    shadow0 <= bus.din;
                                    slot    <= 2'd1;
                                end
                                2'd1: begin
                                    shadow1 <= bus.din;
                                    slot    <= 2'd2;
                                end
                                2'd2: begin
                                    shadow2 <= bus.din;
                                    slot    <= 2'd3;
                                end
                                default: begin
                                    o0_q          <= shadow0;
                                    o1_q          <= shadow1;
                                    o2_q          <= shadow2;
                                    o3_q          <= bus.din;
                                    frame_valid_q <= 1'b1;
                                    slot          <= 2'd0;
                                    state         <= IDLE;
                                end
                            endcase
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o0          = o0_q;
    assign bus.o1          = o1_q;
    assign bus.o2          = o2_q;
    assign bus.o3          = o3_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.s1          = slot[1];
    assign bus.s0          = slot[0];
    assign bus.busy        = (state == RUN);
endmodule

// File: tb/tb_tdm_demux_4.sv
// Directed scenarios for tdm_demux_4 with hand-computed frame and status expectations.
module tb_tdm_demux_4;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    tdm_demux_4_if #(.WIDTH(1)) bus ();

    tdm_demux_4 #(.WIDTH(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one word, take one edge, then sample just after it.
    task automatic drive(input logic v, input logic d, input logic s);
        bus.din_valid = v;
        bus.din       = d;
        bus.sof       = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {bus.o0, bus.o1, bus.o2, bus.o3};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) drive(1'b1, 1'(($urandom)), 1'(($urandom)));
        total++;
        if (outs() !== 4'b0000) begin bad++; $display("FAIL reset_outs got %b want 0000", outs()); end
        total++;
        if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got %b want 0", bus.frame_valid); end
        total++;
        if (bus.sync_err !== 1'b0) begin bad++; $display("FAIL reset_se got %b want 0", bus.sync_err); end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        total++;
        if ({bus.s1, bus.s0} !== 2'b00) begin bad++; $display("FAIL reset_slot got %b want 00", {bus.s1, bus.s0}); end
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_nominal();
        logic [3:0] words;
        logic [1:0] slot_exp [4];
        words = 4'b1010;
        slot_exp = '{2'b01, 2'b10, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[3-i], i == 0);
            total++;
            if ({bus.s1, bus.s0} !== slot_exp[i]) begin
                bad++; $display("FAIL nominal_slot%0d got %b want %b", i, {bus.s1, bus.s0}, slot_exp[i]);
            end
            total++;
            if (bus.frame_valid !== (i == 3)) begin
                bad++; $display("FAIL nominal_fv%0d got %b want %b", i, bus.frame_valid, i == 3);
            end
            total++;
            if (bus.busy !== (i != 3)) begin
                bad++; $display("FAIL nominal_busy%0d got %b want %b", i, bus.busy, i != 3);
            end
        end
        total++;
        if (outs() !== 4'b1010) begin bad++; $display("FAIL nominal_outs got %b want 1010", outs()); end
        drive(1'b0, 1'b0, 1'b0);
        total++;
        if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL nominal_fv_pulse got %b want 0", bus.frame_valid); end
        total++;
        if (outs() !== 4'b1010) begin bad++; $display("FAIL nominal_hold got %b want 1010", outs()); end
    endtask

    task automatic test_gapped();
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1);
            total++;
            if (bus.busy !== 1'b1 || bus.frame_valid !== 1'b0 || {bus.s1, bus.s0} !== 2'b10) begin
                bad++; $display("FAIL gap%0d busy/fv/slot got %b%b%b%b want 1010", i, bus.busy, bus.frame_valid, bus.s1, bus.s0);
            end
        end
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL gapped_fv_early got %b want 0", bus.frame_valid); end
        drive(1'b1, 1'b0, 1'b0);
        total++;
        if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL gapped_fv got %b want 1", bus.frame_valid); end
        total++;
        if (outs() !== 4'b1010) begin bad++; $display("FAIL gapped_outs got %b want 1010", outs()); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_resync();
        int se_cnt;
        int fv_cnt;
        se_cnt = 0;
        fv_cnt = 0;
        drive(1'b1, 1'b1, 1'b1); se_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
        drive(1'b1, 1'b0, 1'b0); se_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
        drive(1'b1, 1'b0, 1'b1); se_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
        total++;
        if (bus.sync_err !== 1'b1 || {bus.s1, bus.s0} !== 2'b01 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL resync_pulse se/slot/busy got %b%b%b%b want 1011", bus.sync_err, bus.s1, bus.s0, bus.busy);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0); se_cnt += int'(bus.sync_err); fv_cnt += int'(bus.frame_valid);
        end
        total++;
        if (bus.frame_valid !== 1'b1 || bus.sync_err !== 1'b0) begin
            bad++; $display("FAIL resync_fv fv/se got %b%b want 10", bus.frame_valid, bus.sync_err);
        end
        total++;
        if (se_cnt !== 1) begin bad++; $display("FAIL resync_se_count got %0d want 1", se_cnt); end
        total++;
        if (fv_cnt !== 1) begin bad++; $display("FAIL resync_fv_count got %0d want 1", fv_cnt); end
        total++;
        if (outs() !== 4'b0111) begin bad++; $display("FAIL resync_outs got %b want 0111", outs()); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words;
        int se_cnt;
        int fv_at [$];
        words = 8'b1100_0101;
        se_cnt = 0;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        total++;
        if (bus.busy !== 1'b0 || {bus.s1, bus.s0} !== 2'b00 || bus.sync_err !== 1'b0) begin
            bad++; $display("FAIL stray busy/slot/se got %b%b%b%b want 0000", bus.busy, bus.s1, bus.s0, bus.sync_err);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, words[7-i], (i % 4) == 0);
            se_cnt += int'(bus.sync_err);
            if (bus.frame_valid === 1'b1) fv_at.push_back(i);
            if (i == 3) begin
                total++;
                if (outs() !== 4'b1100) begin bad++; $display("FAIL b2b_frameA got %b want 1100", outs()); end
            end
        end
        total++;
        if (fv_at.size() !== 2) begin
            bad++; $display("FAIL b2b_fv_count got %0d want 2", fv_at.size());
        end else begin
            total++;
            if (fv_at[1] - fv_at[0] !== 4) begin
                bad++; $display("FAIL b2b_fv_spacing got %0d want 4", fv_at[1] - fv_at[0]);
            end
        end
        total++;
        if (se_cnt !== 0) begin bad++; $display("FAIL b2b_se_count got %0d want 0", se_cnt); end
        total++;
        if (outs() !== 4'b0101) begin bad++; $display("FAIL b2b_frameB got %b want 0101", outs()); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] words;
        int fv_cnt;
        words = 4'b0011;
        fv_cnt = 0;
        drive(1'b1, 1'b1, 1'b1); fv_cnt += int'(bus.frame_valid);
        drive(1'b1, 1'b0, 1'b0); fv_cnt += int'(bus.frame_valid);
        drive(1'b1, 1'b1, 1'b0); fv_cnt += int'(bus.frame_valid);
        total++;
        if (outs() !== 4'b0101) begin bad++; $display("FAIL midrst_prior got %b want 0101", outs()); end
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0); fv_cnt += int'(bus.frame_valid);
        rst = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || {bus.s1, bus.s0} !== 2'b00) begin
            bad++; $display("FAIL midrst_state busy/slot got %b%b%b want 000", bus.busy, bus.s1, bus.s0);
        end
        total++;
        if (fv_cnt !== 0) begin bad++; $display("FAIL midrst_aborted_fv got %0d want 0", fv_cnt); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, words[3-i], i == 0);
            fv_cnt += int'(bus.frame_valid);
        end
        total++;
        if (bus.frame_valid !== 1'b1 || fv_cnt !== 1) begin
            bad++; $display("FAIL midrst_fv got %b cnt %0d want 1 cnt 1", bus.frame_valid, fv_cnt);
        end
        total++;
        if (outs() !== 4'b0011) begin bad++; $display("FAIL midrst_outs got %b want 0011", outs()); end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.din       = 1'b0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        test_reset();
        test_nominal();
        test_gapped();
        test_resync();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
